// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_pkg
// Description : Shared constants and sizing helper for the RAM-backed FIFO.
//               Optional feature macro: RAM_FIFO_FLUSH_EN
// Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    localparam int OB_DEPTH = 2;

    // Level spans RAM content, one in-flight read and the output buffer.
    function automatic int lvl_width(input int ram_size);
        return $clog2(ram_size + OB_DEPTH + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_fifo_outbuf.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_outbuf
// Description : Two-entry output buffer re-timing registered RAM read data
//               onto a valid/ready consumer stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_outbuf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cap_valid,
    input  logic [DATA_WIDTH-1:0] cap_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [1:0]            ob_cnt
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  pop;

    assign pop      = (cnt_q != 2'd0) & rd_ready;
    assign rd_data  = head_q;
    assign rd_valid = (cnt_q != 2'd0);
    assign ob_cnt   = cnt_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = 2'd0;
        end else if (pop) begin
            // Pop frees the head first, so a capture at full occupancy is legal.
            if (cnt_q == 2'd2) begin
                head_d = tail_q;
                if (cap_valid) begin
                    tail_d = cap_data;
                end
                cnt_d = cap_valid ? 2'd2 : 2'd1;
            end else begin
                if (cap_valid) begin
                    head_d = cap_data;
                end
                cnt_d = cap_valid ? 2'd1 : 2'd0;
            end
        end else if (cap_valid) begin
            if (cnt_q == 2'd0) begin
                head_d = cap_data;
            end else begin
                tail_d = cap_data;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Stream FIFO controller driving an external simple dual-port
//               RAM with 1-cycle registered read; owns pointers and counts.
//               Optional feature macro: RAM_FIFO_FLUSH_EN (adds flush input)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter  int RAM_SIZE   = 64,
    parameter  int DATA_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE),
    localparam int LVL_WIDTH  = lvl_width(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_w_enable,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [LVL_WIDTH-1:0]  level
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(RAM_SIZE);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_cnt;
    logic                  flush_req;
    logic                  push;
    logic                  pop;
    logic                  issue;

`ifdef RAM_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Full decision comes from registered count only, never from this cycle's issue.
    assign wr_ready = (ram_cnt_q != CNT_FULL) & ~flush_req;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    // Issue only if the buffer can absorb the returning word: ob + inflight - pop < 2.
    assign issue = (ram_cnt_q != '0) &
                   (({1'b0, ob_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = 1'b0;
        if (!flush_req) begin
            wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
            ram_cnt_d  = ram_cnt_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
            inflight_d = issue;
        end else begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    ram_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_req),
        .cap_valid (inflight_q),
        .cap_data  (ram_data_out),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .ob_cnt    (ob_cnt)
    );

    assign ram_data_in  = wr_data;
    assign ram_w_addr   = wr_ptr_q;
    assign ram_w_enable = push;
    assign ram_r_addr   = rd_ptr_q;

    assign level = LVL_WIDTH'(ram_cnt_q) + LVL_WIDTH'(inflight_q) + LVL_WIDTH'(ob_cnt);

endmodule
`default_nettype wire
